cache_refill_ctrl_16: RTL and testbench
=======================================

# cache_refill_ctrl_16

Memory-side responder for the step-4 16-word direct-mapped cache.
- Accepts a line request from the step-4 cache controller: a read miss, or a store (`sw`, write-through with write-allocate).
- Runs the transaction against the synchronous main memory.
- Streams the four words of the addressed line back into the cache as per-word fill strobes.
- Holds the pipeline stall for the whole transaction.

## Interface
Parameters:
- WIDTH, 32, data word width
- MEM_SIZE, 32, main memory size in words; address is 5 bits {tag[4], index[3:2], offset[1:0]}
- CACHE_SIZE, 16, cache words: 4 lines × 4 words

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request from step-4 controller (miss or store)
- req_write  in  1  1 = store (write-through then line fill), 0 = read miss
- req_addr  in  5  word address {tag, index, offset}
- req_wdata  in  WIDTH  store data
- req_ready  out  1  block idle, request accepted this edge if req_valid
- stall  out  1  pipeline hold; high while a transaction is in progress
- mem_addr  out  5  memory word address
- mem_rd  out  1  memory read strobe; data on mem_rdata next cycle
- mem_wr  out  1  memory write strobe
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data, one cycle after mem_rd
- fill_valid  out  1  write fill_data into the cache word at {fill_index, fill_offset}
- fill_tag  out  1  tag stored for the line
- fill_index  out  2  cache line being filled
- fill_offset  out  2  word within the line
- fill_data  out  WIDTH  equals mem_rdata
- fill_done  out  1  one-cycle pulse: line complete, set valid/tag

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1, stall=0.
  - On req_valid: capture addr and wdata. Go to WRITE if req_write, else READ.
- WRITE (1 cycle):
  - mem_wr=1, mem_addr=captured addr, mem_wdata=captured data.
  - Then go to READ (write-allocate).
- READ (4 cycles, 2-bit issue counter k=0..3):
  - mem_rd=1, mem_addr={tag, index, start+k}. Offset is added mod 4 and wraps within the line; it never carries into index.
  - After k=3, go to DRAIN.
- Return pipe:
  - A registered copy of the issue (valid, offset) produces fill_valid/fill_offset one cycle after each mem_rd.
  - fill_tag/fill_index come from the captured address.
- DRAIN (1 cycle):
  - Last fill_valid. fill_done=1 in the same cycle.
  - Go to IDLE.
- The memory is read-after-write coherent: a WRITE followed by a READ of the same word returns the new data.
- req_valid while not IDLE is ignored. The requester must hold it until req_ready.
- stall = (state != IDLE).
- mem_* and fill_* strobes are 0 in every state not listed above.

## Timing
- Request sampled at edge 0.
- Read miss:
  - mem_rd in cycles 1–4.
  - fill_valid in cycles 2–5.
  - fill_done in cycle 5.
  - req_ready=1 in cycle 6.
- Store:
  - mem_wr in cycle 1.
  - mem_rd in cycles 2–5.
  - fill_valid in cycles 3–6.
  - fill_done in cycle 6.
  - req_ready in cycle 7.
- req_valid held high continuously: next request accepted on the first edge with req_ready=1. No idle gap beyond that.
- Reset:
  - While rst=1, req_ready=0. All other outputs, counters and captured registers are 0.
  - After rst deasserts, state is IDLE.
- Reset mid-transaction:
  - Aborts at the edge. No further mem_*/fill_* strobes.
  - fill_done never pulses for the aborted line. The cache must treat that line as invalid.
- fill_data is combinational from mem_rdata. All other outputs are state/register driven.

## Configuration
- REFILL_CWF_EN defined (critical word first):
  - start = req_addr offset.
  - Burst order is offset, offset+1, … mod 4. The requested word is filled first, in cycle 2 for a read miss.
- REFILL_CWF_EN undefined:
  - start = 0. Burst order is always 0,1,2,3.
  - The requested offset is ignored for the burst. It is still used for the WRITE address.

## Test plan
- Read miss, CWF off:
  - Stimulus: req_addr=5'b1_10_01.
  - Required: mem_addr 5'b1_10_00..1_10_11 in cycles 1–4; fill_valid offsets 0,1,2,3 in cycles 2–5 with fill_index=2, fill_tag=1; fill_done in cycle 5; stall high in cycles 1–5.
- Same request with REFILL_CWF_EN:
  - Required: offsets 1,2,3,0, wrapping without touching index; fill_done in cycle 5.
- Store:
  - Stimulus: req_addr=5'b0_01_11, req_wdata=0xDEADBEEF.
  - Required: mem_wr in cycle 1 with that address and data; fill_data=0xDEADBEEF at offset 3 in cycle 6; fill_done in cycle 6.
- Request while busy:
  - Stimulus: pulse a second req_valid at cycle 3 of a read miss.
  - Required: no effect; only the first line is filled.
- Reset mid-burst:
  - Stimulus: rst=1 for one cycle at cycle 3.
  - Required: next cycle all strobes 0 and no fill_done; req_ready=1 after rst falls; a new miss then completes normally.
- Back-to-back:
  - Stimulus: req_valid held with two read addresses.
  - Required: second accepted at the edge closing cycle 6; its mem_rd begins in cycle 7.

Source files
------------

// File: rtl/cache_refill_ctrl_16.sv
// Line-refill responder for the 16-word direct-mapped cache: write-through store, 4-word burst read, fill strobes.
// Optional critical-word-first burst ordering is enabled by defining REFILL_CWF_EN.
module cache_refill_ctrl_16 #(
    parameter int WIDTH = 32,
    parameter int MEM_SIZE = 32,
    parameter int CACHE_SIZE = 16,
    localparam int AW = $clog2(MEM_SIZE),
    localparam int IW = $clog2(CACHE_SIZE / 4),
    localparam int TW = AW - IW - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ready,
    output logic             stall,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             fill_valid,
    output logic [TW-1:0]    fill_tag,
    output logic [IW-1:0]    fill_index,
    output logic [1:0]       fill_offset,
    output logic [WIDTH-1:0] fill_data,
    output logic             fill_done
);

`ifdef REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_r;
    logic [AW-3:0]     line_r;
    logic [1:0]        start_r;
    logic [1:0]        k_r;
    logic              req_ready_r;
    logic              stall_r;
    logic [AW-1:0]     mem_addr_r;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic [WIDTH-1:0]  mem_wdata_r;
    logic              fill_valid_r;
    logic [1:0]        fill_offset_r;
    logic              fill_done_r;
    logic [1:0]        req_start_s;

    assign req_start_s = CWF ? req_addr[1:0] : 2'b00;

    // Transaction FSM with all outputs registered; the fill pipe is a one-cycle copy of the read issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            line_r        <= {(AW-2){1'b0}};
            start_r       <= 2'b00;
            k_r           <= 2'b00;
            req_ready_r   <= 1'b0;
            stall_r       <= 1'b0;
            mem_addr_r    <= {AW{1'b0}};
            mem_rd_r      <= 1'b0;
            mem_wr_r      <= 1'b0;
            mem_wdata_r   <= {WIDTH{1'b0}};
            fill_valid_r  <= 1'b0;
            fill_offset_r <= 2'b00;
            fill_done_r   <= 1'b0;
        end else begin
            fill_valid_r  <= mem_rd_r;
            fill_offset_r <= mem_rd_r ? mem_addr_r[1:0] : 2'b00;
            fill_done_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    mem_rd_r    <= 1'b0;
                    mem_wr_r    <= 1'b0;
                    mem_addr_r  <= {AW{1'b0}};
                    mem_wdata_r <= {WIDTH{1'b0}};
                    k_r         <= 2'b00;
                    if (req_ready_r && req_valid) begin
                        line_r      <= req_addr[AW-1:2];
                        start_r     <= req_start_s;
                        req_ready_r <= 1'b0;
                        stall_r     <= 1'b1;
                        if (req_write) begin
                            state_r     <= WRITE;
                            mem_wr_r    <= 1'b1;
                            mem_addr_r  <= req_addr;
                            mem_wdata_r <= req_wdata;
                        end else begin
                            state_r    <= READ;
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= {req_addr[AW-1:2], req_start_s};
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                        stall_r     <= 1'b0;
                    end
                end
                WRITE: begin
                    state_r     <= READ;
                    mem_wr_r    <= 1'b0;
                    mem_wdata_r <= {WIDTH{1'b0}};
                    mem_rd_r    <= 1'b1;
                    mem_addr_r  <= {line_r, start_r};
                    k_r         <= 2'b00;
                end
                READ: begin
                    if (k_r == 2'd3) begin
                        state_r     <= DRAIN;
                        mem_rd_r    <= 1'b0;
                        mem_addr_r  <= {AW{1'b0}};
                        k_r         <= 2'b00;
                        fill_done_r <= 1'b1;
                    end else begin
                        // Offset arithmetic is 2 bits wide so the burst wraps inside the line.
                        k_r        <= k_r + 2'd1;
                        mem_addr_r <= {line_r, start_r + k_r + 2'd1};
                    end
                end
                DRAIN: begin
                    state_r     <= IDLE;
                    stall_r     <= 1'b0;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    stall_r     <= 1'b0;
                    req_ready_r <= 1'b0;
                    mem_rd_r    <= 1'b0;
                    mem_wr_r    <= 1'b0;
                    mem_addr_r  <= {AW{1'b0}};
                    mem_wdata_r <= {WIDTH{1'b0}};
                    k_r         <= 2'b00;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign stall       = stall_r;
    assign mem_addr    = mem_addr_r;
    assign mem_rd      = mem_rd_r;
    assign mem_wr      = mem_wr_r;
    assign mem_wdata   = mem_wdata_r;
    assign fill_valid  = fill_valid_r;
    assign fill_offset = fill_offset_r;
    assign fill_done   = fill_done_r;
    assign fill_tag    = line_r[AW-3 -: TW];
    assign fill_index  = line_r[IW-1:0];
    assign fill_data   = mem_rdata;

endmodule

// File: tb/tb_cache_refill_ctrl_16.sv
// Scoreboard bench for cache_refill_ctrl_16: driver queues expected memory/fill events, monitor checks them per cycle.
module tb_cache_refill_ctrl_16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [4:0]  req_addr = 5'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, stall, mem_rd, mem_wr, fill_valid, fill_done;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, fill_data;
    logic [31:0] mem_rdata = 32'd0;
    logic [0:0]  fill_tag;
    logic [1:0]  fill_index, fill_offset;

    cache_refill_ctrl_16 #(.WIDTH(32), .MEM_SIZE(32), .CACHE_SIZE(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fill_valid(fill_valid), .fill_tag(fill_tag),
        .fill_index(fill_index), .fill_offset(fill_offset), .fill_data(fill_data),
        .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          addr;
        int          tag;
        int          idx;
        int          off;
        logic [31:0] data;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];
    exp_t fill_q[$];
    int   done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int win_lo = 1;
    int win_hi = 0;
    int ready_from = 1 << 30;
    bit mon_en = 1'b0;
    int unsigned seed = 32'd0;
    logic        mem_loaded = 1'b0;
    logic [31:0] mem_model [32];
    logic [31:0] ref_mem [32];

    function automatic logic [31:0] init_word(input int i);
        return seed ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    function automatic int start_off(input int a);
`ifdef REFILL_CWF_EN
        return a % 4;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act_v, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous main memory: read data one cycle after mem_rd, loaded once at start.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem_model[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_wr === 1'b1) mem_model[mem_addr] <= mem_wdata;
            if (mem_rd === 1'b1) mem_rdata <= mem_model[mem_addr];
        end
    end

    // Monitor: every cycle, each strobe must match whether the queue head is due now.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   due;
            bit   exp_stall;
            exp_t e;
            exp_stall = (cyc >= win_lo) && (cyc <= win_hi);
            check("stall", 64'(stall), 64'(exp_stall));
            check("req_ready", 64'(req_ready), 64'(!exp_stall && cyc >= ready_from));

            due = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            check("mem_wr", 64'(mem_wr), 64'(due));
            if (due) begin
                e = wr_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end

            due = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            check("mem_rd", 64'(mem_rd), 64'(due));
            if (due) begin
                e = rd_q.pop_front();
                check("rd_addr", 64'(mem_addr), 64'(e.addr));
            end

            due = (fill_q.size() > 0) && (fill_q[0].cyc == cyc);
            check("fill_valid", 64'(fill_valid), 64'(due));
            if (due) begin
                e = fill_q.pop_front();
                check("fill_tag", 64'(fill_tag), 64'(e.tag));
                check("fill_index", 64'(fill_index), 64'(e.idx));
                check("fill_offset", 64'(fill_offset), 64'(e.off));
                check("fill_data", 64'(fill_data), 64'(e.data));
            end

            due = (done_q.size() > 0) && (done_q[0] == cyc);
            check("fill_done", 64'(fill_done), 64'(due));
            if (due) void'(done_q.pop_front());
        end
    end

    // Issue one request; returns the cycle in which the accepting edge closes.
    task automatic issue(input bit wr, input int addr, input logic [31:0] data, input bit hold,
                         output int acc);
        int   n;
        int   m;
        int   w;
        int   base;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = 5'(addr);
        req_wdata = data;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 40), 64'(1));
        m = cyc;
        acc = m;
        w = wr ? 1 : 0;
        if (wr) begin
            e.cyc = m + 1; e.addr = addr; e.data = data; e.tag = 0; e.idx = 0; e.off = 0;
            wr_q.push_back(e);
            ref_mem[addr] = data;
        end
        base = addr - (addr % 4);
        for (int i = 0; i < 4; i++) begin
            e.off  = (start_off(addr) + i) % 4;
            e.addr = base + e.off;
            e.tag  = addr / 16;
            e.idx  = (addr / 4) % 4;
            e.data = ref_mem[base + e.off];
            e.cyc  = m + 1 + w + i;
            rd_q.push_back(e);
            e.cyc  = m + 2 + w + i;
            fill_q.push_back(e);
        end
        done_q.push_back(m + 5 + w);
        win_lo = m + 1;
        win_hi = m + 5 + w;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((fill_q.size() > 0 || done_q.size() > 0 || req_ready !== 1'b1) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n < 30), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int m1;
        int m2;
        seed = $urandom;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_mem_rd", 64'(mem_rd), 64'(0));
        check("rst_mem_wr", 64'(mem_wr), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_fill_valid", 64'(fill_valid), 64'(0));
        check("rst_fill_done", 64'(fill_done), 64'(0));
        check("rst_fill_pos", 64'({fill_tag, fill_index, fill_offset}), 64'(0));
        rst = 1'b0;
        ready_from = cyc + 1;
        mon_en = 1'b1;

        // Directed: read miss, store, request while busy
        issue(1'b0, 25, 32'd0, 1'b0, m1);
        wait_idle();
        issue(1'b1, 7, 32'hDEAD_BEEF, 1'b0, m1);
        wait_idle();
        issue(1'b0, 10, 32'd0, 1'b0, m1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd30; req_wdata = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a burst
        issue(1'b0, 19, 32'd0, 1'b0, m1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_q.delete(); rd_q.delete(); fill_q.delete(); done_q.delete();
        win_lo = 1; win_hi = 0;
        ready_from = cyc + 1;
        @(negedge clk);
        check("abort_fill_done", 64'(fill_done), 64'(0));
        check("abort_strobes", 64'({mem_rd, mem_wr, fill_valid}), 64'(0));
        wait_idle();
        issue(1'b0, 19, 32'd0, 1'b0, m1);
        wait_idle();

        // Back-to-back with req_valid held
        issue(1'b0, 5, 32'd0, 1'b1, m1);
        issue(1'b0, 22, 32'd0, 1'b0, m2);
        check("b2b_gap", 64'(m2 - m1), 64'(6));
        wait_idle();

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            bit wr;
            bit h;
            wr = 1'($urandom_range(0, 1));
            h  = (t < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            issue(wr, int'($urandom_range(0, 31)), $urandom, h, m1);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check("wr_q_empty", 64'(wr_q.size()), 64'(0));
        check("rd_q_empty", 64'(rd_q.size()), 64'(0));
        check("fill_q_empty", 64'(fill_q.size()), 64'(0));
        check("done_q_empty", 64'(done_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
